// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a
// 2-entry buffer of long-latency load responses, with starvation-forced drain.
module wb_port_arbiter #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_regWrite,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  mem_resp_valid,
  input  logic [4:0]            mem_resp_rd,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  mem_resp_ready,
  output logic                  rf_write,
  output logic [4:0]            rf_write_reg,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  wb_stall,
  output logic [1:0]            fifo_count
);

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [1:0][4:0]              ent_rd_q, ent_rd_d;
  logic [1:0][DATA_WIDTH-1:0]   ent_data_q, ent_data_d;
  logic [1:0]                   ent_kill_q, ent_kill_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic [3:0]                   starve_q, starve_d;
  logic                         rf_write_q, rf_write_d;
  logic [4:0]                   rf_write_reg_q, rf_write_reg_d;
  logic [DATA_WIDTH-1:0]        rf_write_data_q, rf_write_data_d;
  logic                         wb_stall_q, wb_stall_d;

  logic live, push, pop, grant_pipe;

  logic unused_params;
  assign unused_params = (CORE != 0) ^ (ADDRESS_BITS != 0);

  assign mem_resp_ready = (count_q != 2'd2);

  always_comb begin
    live       = wb_regWrite && (wb_rd != 5'd0) && !wb_stall_q;
    push       = mem_resp_valid && mem_resp_ready && (mem_resp_rd != 5'd0);
    grant_pipe = (state_q == NORMAL) && live;
    pop        = !grant_pipe && (count_q != 2'd0);

    state_d         = state_q;
    ent_rd_d        = ent_rd_q;
    ent_data_d      = ent_data_q;
    ent_kill_d      = ent_kill_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    starve_d        = starve_q;
    rf_write_d      = 1'b0;
    rf_write_reg_d  = 5'd0;
    rf_write_data_d = '0;

    if (grant_pipe) begin
      rf_write_d      = 1'b1;
      rf_write_reg_d  = wb_rd;
      rf_write_data_d = wb_write_data;
      // Older buffered results to the same register must never land afterwards.
      for (int i = 0; i < 2; i++)
        if (ent_rd_q[i] == wb_rd) ent_kill_d[i] = 1'b1;
    end else if (pop) begin
      rf_write_d = !ent_kill_q[rd_ptr_q];
      if (!ent_kill_q[rd_ptr_q]) begin
        rf_write_reg_d  = ent_rd_q[rd_ptr_q];
        rf_write_data_d = ent_data_q[rd_ptr_q];
      end
      rd_ptr_d = ~rd_ptr_q;
    end

    // Applied after the kill scan so a same-cycle response stays live.
    if (push) begin
      ent_rd_d[wr_ptr_q]   = mem_resp_rd;
      ent_data_d[wr_ptr_q] = mem_resp_data;
      ent_kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d             = ~wr_ptr_q;
    end

    count_d = count_q + 2'(push) - 2'(pop);

    if (count_q == 2'd0 || pop) starve_d = 4'd0;
    else if (starve_q != 4'd15) starve_d = starve_q + 4'd1;

    if (state_q == NORMAL) begin
      if (count_d == 2'd2 || starve_d >= 4'(STARVE_LIMIT)) state_d = DRAIN;
    end else if (count_d == 2'd0) begin
      state_d = NORMAL;
    end

    wb_stall_d = (state_d == DRAIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= NORMAL;
      ent_rd_q        <= '0;
      ent_data_q      <= '0;
      ent_kill_q      <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      starve_q        <= 4'd0;
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= 5'd0;
      rf_write_data_q <= '0;
      wb_stall_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ent_rd_q        <= ent_rd_d;
      ent_data_q      <= ent_data_d;
      ent_kill_q      <= ent_kill_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      rf_write_q      <= rf_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      wb_stall_q      <= wb_stall_d;
    end
  end

  assign rf_write      = rf_write_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;
  assign wb_stall      = wb_stall_q;
  assign fifo_count    = count_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter CORE, default 0, core index, no functional effect.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter ADDRESS_BITS, default 20, carried for consistency, unused.
REQ-004 Parameter STARVE_LIMIT, default 4, max cycles a buffered response waits before forced drain; legal range 1..15.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 wb_regWrite  in  1  pipeline writeback request.
REQ-009 wb_rd  in  5  pipeline destination register.
REQ-010 wb_write_data  in  DATA_WIDTH  pipeline writeback value.
REQ-011 mem_resp_valid  in  1  long-latency load response valid.
REQ-012 mem_resp_rd  in  5  response destination register.
REQ-013 mem_resp_data  in  DATA_WIDTH  response value.
REQ-014 mem_resp_ready  out  1  response accepted this cycle when high with valid.
REQ-015 rf_write  out  1  register-file write enable, registered.
REQ-016 rf_write_reg  out  5  register-file write address, registered.
REQ-017 rf_write_data  out  DATA_WIDTH  register-file write data, registered.
REQ-018 wb_stall  out  1  pipeline freeze request, registered.
REQ-019 fifo_count  out  2  number of buffered responses (0..2).

Function
REQ-020 Block SHALL share the single register-file write port between pipeline writeback and a 2-entry response FIFO.
REQ-021 Pipeline request SHALL be live when wb_regWrite=1, wb_rd!=0, wb_stall=0; otherwise ignored.
REQ-022 mem_resp_ready SHALL equal (fifo_count!=2), combinational from state only, never from mem_resp_valid.
REQ-023 Push on mem_resp_valid && mem_resp_ready; response with rd=0 SHALL be accepted and discarded (no push).
REQ-024 No bypass: pushed entry earliest write is the cycle after push.
REQ-025 FSM states NORMAL, DRAIN; reset state NORMAL.
REQ-026 NORMAL grant: live pipeline request wins; else FIFO head popped if nonempty; else no write.
REQ-027 DRAIN grant: FIFO head popped every cycle; pipeline request never granted.
REQ-028 Granted source drives rf_write/rf_write_reg/rf_write_data at next rising edge (latency 1); rf_write=0 when no grant.
REQ-029 Starve counter (4 bits) SHALL clear when FIFO empty or head popped, else increment, saturating at 15.
REQ-030 NORMAL->DRAIN when, after this cycle's push/pop, FIFO is full or starve counter reaches STARVE_LIMIT.
REQ-031 DRAIN->NORMAL when FIFO becomes empty at end of cycle; wb_stall registered, =1 exactly while in DRAIN.
REQ-032 WAW kill: when a pipeline write is granted to rd R, every FIFO entry with rd R SHALL be marked killed.
REQ-033 Killed entry SHALL still pop in order but produce rf_write=0 that cycle.
REQ-034 Entry pushed in the same cycle as a matching pipeline grant SHALL NOT be killed (response is younger).
REQ-035 Simultaneous push and pop SHALL keep fifo_count unchanged and preserve FIFO order.
REQ-036 FIFO pointers SHALL wrap modulo 2.

Reset
REQ-037 On reset: state NORMAL, FIFO empty, kill bits 0, starve counter 0, rf_write=0, rf_write_reg=0, rf_write_data=0, wb_stall=0, fifo_count=0.
REQ-038 Reset mid-drain SHALL discard buffered responses without writing them; mem_resp_ready=1 the cycle after reset.

Verification
REQ-039 Pipeline only: wb_regWrite=1, wb_rd=5, data 0xA5 -> next cycle rf_write=1, reg 5, data 0xA5, wb_stall=0.
REQ-040 Idle pipeline: response rd=7 data 0x11 at cycle 0 -> fifo_count=1 at cycle 1, rf_write reg 7 data 0x11 at cycle 2.
REQ-041 Continuous pipeline writes, one response, STARVE_LIMIT=4 -> wb_stall=1 after 4 waiting cycles, response written, wb_stall=0 when FIFO empty.
REQ-042 Two responses back-to-back under continuous pipeline writes -> FIFO full, mem_resp_ready=0, DRAIN entered, both written in order, ready returns to 1.
REQ-043 Response rd=3 buffered, pipeline writes rd=3 value 0x22 -> later pop gives rf_write=0; register 3 final value 0x22.
REQ-044 Assert reset while in DRAIN with 2 entries -> next cycle all outputs 0, fifo_count=0, no buffered write ever appears.
